// File: rtl/issue_queue_pkg.sv
// ----------------------------------------------------------------------------
// issue_queue_pkg
//   Shared definitions for the decode -> issue -> register-read path.
//   REG_IDX_W : architectural register index width
//   INST_NOP  : canonical NOP encoding used upstream when building payloads
//   PC_RESET  : reset fetch address, also used upstream in payloads
//   slot_meta_t : per-slot scheduling fields kept next to the opaque payload
//   lane_count  : number of set lanes in a 2-lane valid vector
// ----------------------------------------------------------------------------
package issue_queue_pkg;

  localparam int          REG_IDX_W = 5;
  localparam logic [31:0] INST_NOP  = 32'h0340_0000;
  localparam logic [31:0] PC_RESET  = 32'h1c00_0000;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [REG_IDX_W-1:0] rj;
    logic [REG_IDX_W-1:0] rk;
    logic                 is_alu;
    logic                 is_priv;
  } slot_meta_t;

  // Lane vectors are always 2'b00, 2'b01 or 2'b11, so lane1 implies two.
  function automatic logic [1:0] lane_count(input logic [1:0] valid);
    if (valid[1])      return 2'd2;
    else if (valid[0]) return 2'd1;
    else               return 2'd0;
  endfunction

endpackage

// File: rtl/issue_pair_check.sv
// ----------------------------------------------------------------------------
// issue_pair_check
//   Decides whether the head entry and the one behind it may issue together.
//   Both must be simple ALU ops, neither may be privileged, and the younger
//   one must not read the older one's destination (r0 never creates a RAW).
//   Ports:
//     head_rd, head_is_alu, head_is_priv   : fields of the older (head) entry
//     next_rj, next_rk, next_is_alu,
//     next_is_priv                         : fields of the younger entry
//     pair_ok                              : dual issue permitted
// ----------------------------------------------------------------------------
module issue_pair_check
  import issue_queue_pkg::*;
(
  input  logic [REG_IDX_W-1:0] head_rd,
  input  logic                 head_is_alu,
  input  logic                 head_is_priv,
  input  logic [REG_IDX_W-1:0] next_rj,
  input  logic [REG_IDX_W-1:0] next_rk,
  input  logic                 next_is_alu,
  input  logic                 next_is_priv,
  output logic                 pair_ok
);

  logic no_raw;

  // WAR/WAW cannot bite because issue stays in order; only RAW matters.
  assign no_raw  = (head_rd == '0) | ((head_rd != next_rj) & (head_rd != next_rk));
  assign pair_ok = head_is_alu & next_is_alu & ~head_is_priv & ~next_is_priv & no_raw;

endmodule

// File: rtl/issue_queue.sv
// ----------------------------------------------------------------------------
// issue_queue
//   In-order issue buffer between decode and register read. Up to two
//   instructions enqueue per cycle into a DEPTH-slot circular buffer; one or
//   two issue per cycle from the head, two only when issue_pair_check agrees.
//   A privileged op leaving the queue blocks issue for the following cycle.
//   Ports:
//     clk, rstn            : clock, asynchronous active-low reset
//     flush                : drop every queued entry
//     in_valid[1:0]        : enqueue lanes (lane0 older, lane1 only with lane0)
//     in_ready             : room for two entries this cycle
//     in_payload/rd/rj/rk/is_alu/is_priv 0/1 : incoming entry fields
//     out_valid[1:0]       : issue lanes (never 2'b10)
//     out_ready            : downstream takes every valid lane
//     out_payload/rd/rj/rk/is_alu/is_priv 0/1 : head and head+1 entries
//     out_single           : only lane0 issues this cycle
//     occupancy            : current number of entries
// ----------------------------------------------------------------------------
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int PAYLOAD_W = 160,
  parameter int DUAL_EN   = 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   flush,
  input  logic [1:0]             in_valid,
  output logic                   in_ready,
  input  logic [PAYLOAD_W-1:0]   in_payload0,
  input  logic [PAYLOAD_W-1:0]   in_payload1,
  input  logic [REG_IDX_W-1:0]   in_rd0,
  input  logic [REG_IDX_W-1:0]   in_rd1,
  input  logic [REG_IDX_W-1:0]   in_rj0,
  input  logic [REG_IDX_W-1:0]   in_rj1,
  input  logic [REG_IDX_W-1:0]   in_rk0,
  input  logic [REG_IDX_W-1:0]   in_rk1,
  input  logic                   in_is_alu0,
  input  logic                   in_is_alu1,
  input  logic                   in_is_priv0,
  input  logic                   in_is_priv1,
  output logic [1:0]             out_valid,
  input  logic                   out_ready,
  output logic [PAYLOAD_W-1:0]   out_payload0,
  output logic [PAYLOAD_W-1:0]   out_payload1,
  output logic [REG_IDX_W-1:0]   out_rd0,
  output logic [REG_IDX_W-1:0]   out_rd1,
  output logic [REG_IDX_W-1:0]   out_rj0,
  output logic [REG_IDX_W-1:0]   out_rj1,
  output logic [REG_IDX_W-1:0]   out_rk0,
  output logic [REG_IDX_W-1:0]   out_rk1,
  output logic                   out_is_alu0,
  output logic                   out_is_alu1,
  output logic                   out_is_priv0,
  output logic                   out_is_priv1,
  output logic                   out_single,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [PTR_W-1:0]     head1;
  logic [PTR_W-1:0]     tail1;
  logic [CNT_W-1:0]     count;
  logic                 priv_hold;

  logic [PAYLOAD_W-1:0] slot_payload [DEPTH];
  slot_meta_t           slot_meta    [DEPTH];

  slot_meta_t           head_meta;
  slot_meta_t           next_meta;
  slot_meta_t           in_meta0;
  slot_meta_t           in_meta1;
  logic                 pair_ok;
  logic                 valid0;
  logic                 valid1;
  logic                 enq_fire;
  logic                 deq_fire;
  logic [1:0]           enq_n;
  logic [1:0]           deq_n;

  // Pointers are exactly log2(DEPTH) bits, so +1 wraps modulo DEPTH.
  assign head1     = head + PTR_W'(1);
  assign tail1     = tail + PTR_W'(1);
  assign head_meta = slot_meta[head];
  assign next_meta = slot_meta[head1];
  assign in_meta0  = '{rd: in_rd0, rj: in_rj0, rk: in_rk0, is_alu: in_is_alu0, is_priv: in_is_priv0};
  assign in_meta1  = '{rd: in_rd1, rj: in_rj1, rk: in_rk1, is_alu: in_is_alu1, is_priv: in_is_priv1};

  issue_pair_check u_pair_check (
    .head_rd      (head_meta.rd),
    .head_is_alu  (head_meta.is_alu),
    .head_is_priv (head_meta.is_priv),
    .next_rj      (next_meta.rj),
    .next_rk      (next_meta.rk),
    .next_is_alu  (next_meta.is_alu),
    .next_is_priv (next_meta.is_priv),
    .pair_ok      (pair_ok)
  );

  // in_ready looks only at the current count: a same-cycle dequeue does not
  // make room, which keeps in_ready off the downstream ready path.
  assign in_ready = (count <= CNT_W'(DEPTH - 2));
  assign valid0   = (count != '0) & ~priv_hold;
  assign valid1   = valid0 & (count >= CNT_W'(2)) & (DUAL_EN != 0) & pair_ok;

  // Flush wins over both sides, so nothing is written, counted or popped.
  assign enq_fire = in_ready & in_valid[0] & ~flush;
  assign deq_fire = out_ready & valid0 & ~flush;
  assign enq_n    = enq_fire ? lane_count(in_valid) : 2'd0;
  assign deq_n    = deq_fire ? lane_count({valid1, valid0}) : 2'd0;

  // Pointer, count and priv-serialisation state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      priv_hold <= 1'b0;
    end else if (flush) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      priv_hold <= 1'b0;
    end else begin
      head      <= head + PTR_W'(deq_n);
      tail      <= tail + PTR_W'(enq_n);
      count     <= count + CNT_W'(enq_n) - CNT_W'(deq_n);
      // A priv op never pairs, so it always leaves alone in lane0; while the
      // hold is up valid0 is low, so the hold drops again next cycle.
      priv_hold <= deq_fire & head_meta.is_priv;
    end
  end

  // Slot storage carries no reset; count alone says which slots are live.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      slot_payload[tail] <= in_payload0;
      slot_meta[tail]    <= in_meta0;
      if (in_valid[1]) begin
        slot_payload[tail1] <= in_payload1;
        slot_meta[tail1]    <= in_meta1;
      end
    end
  end

  assign out_valid    = {valid1, valid0};
  assign out_single   = valid0 & ~valid1;
  assign occupancy    = count;

  assign out_payload0 = slot_payload[head];
  assign out_rd0      = head_meta.rd;
  assign out_rj0      = head_meta.rj;
  assign out_rk0      = head_meta.rk;
  assign out_is_alu0  = head_meta.is_alu;
  assign out_is_priv0 = head_meta.is_priv;

  // When lane1 does not issue, rd=0 / is_alu=1 present it as a NOP slot.
  assign out_payload1 = slot_payload[head1];
  assign out_rd1      = valid1 ? next_meta.rd : '0;
  assign out_rj1      = next_meta.rj;
  assign out_rk1      = next_meta.rk;
  assign out_is_alu1  = valid1 ? next_meta.is_alu : 1'b1;
  assign out_is_priv1 = next_meta.is_priv;

  a_no_lane1_alone: assert property (@(posedge clk) disable iff (!rstn) in_valid != 2'b10);
  a_count_bound:    assert property (@(posedge clk) disable iff (!rstn) count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_issue_queue.sv
// ----------------------------------------------------------------------------
// tb_issue_queue
//   Drives a dual-issue and a single-issue instance of issue_queue from the
//   same inputs. Accepted entries are pushed into a per-instance scoreboard
//   queue; a monitor compares each instance's outputs against the head of
//   its queue every cycle and pops what the instance issues.
// ----------------------------------------------------------------------------
module tb_issue_queue;

  localparam int DEPTH = 8;
  localparam int PW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [PW-1:0] payload;
    logic [4:0]    rd;
    logic [4:0]    rj;
    logic [4:0]    rk;
    logic          alu;
    logic          priv;
  } ent_t;

  logic       clk       = 1'b0;
  logic       rstn      = 1'b0;
  logic       flush     = 1'b0;
  logic       out_ready = 1'b0;
  logic [1:0] in_valid  = 2'b00;
  ent_t       in_e0     = '0;
  ent_t       in_e1     = '0;

  logic          o_in_ready [2];
  logic [1:0]    o_valid    [2];
  logic          o_single   [2];
  logic [CW-1:0] o_occ      [2];
  logic [PW-1:0] o_pl0 [2], o_pl1 [2];
  logic [4:0]    o_rd0 [2], o_rd1 [2], o_rj0 [2], o_rj1 [2], o_rk0 [2], o_rk1 [2];
  logic          o_alu0 [2], o_alu1 [2], o_priv0 [2], o_priv1 [2];

  ent_t qa[$];
  ent_t qb[$];
  bit   hold   [2];
  int   cnt_at [2];
  int   n_vec  = 0;
  int   n_err  = 0;
  int   seq    = 0;

  always #5 clk = ~clk;

  issue_queue #(.DEPTH(DEPTH), .PAYLOAD_W(PW), .DUAL_EN(1)) u_dut (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(o_in_ready[0]),
    .in_payload0(in_e0.payload), .in_payload1(in_e1.payload),
    .in_rd0(in_e0.rd), .in_rd1(in_e1.rd), .in_rj0(in_e0.rj), .in_rj1(in_e1.rj),
    .in_rk0(in_e0.rk), .in_rk1(in_e1.rk), .in_is_alu0(in_e0.alu), .in_is_alu1(in_e1.alu),
    .in_is_priv0(in_e0.priv), .in_is_priv1(in_e1.priv),
    .out_valid(o_valid[0]), .out_ready(out_ready),
    .out_payload0(o_pl0[0]), .out_payload1(o_pl1[0]),
    .out_rd0(o_rd0[0]), .out_rd1(o_rd1[0]), .out_rj0(o_rj0[0]), .out_rj1(o_rj1[0]),
    .out_rk0(o_rk0[0]), .out_rk1(o_rk1[0]), .out_is_alu0(o_alu0[0]), .out_is_alu1(o_alu1[0]),
    .out_is_priv0(o_priv0[0]), .out_is_priv1(o_priv1[0]),
    .out_single(o_single[0]), .occupancy(o_occ[0])
  );

  issue_queue #(.DEPTH(DEPTH), .PAYLOAD_W(PW), .DUAL_EN(0)) u_dut_single (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(o_in_ready[1]),
    .in_payload0(in_e0.payload), .in_payload1(in_e1.payload),
    .in_rd0(in_e0.rd), .in_rd1(in_e1.rd), .in_rj0(in_e0.rj), .in_rj1(in_e1.rj),
    .in_rk0(in_e0.rk), .in_rk1(in_e1.rk), .in_is_alu0(in_e0.alu), .in_is_alu1(in_e1.alu),
    .in_is_priv0(in_e0.priv), .in_is_priv1(in_e1.priv),
    .out_valid(o_valid[1]), .out_ready(out_ready),
    .out_payload0(o_pl0[1]), .out_payload1(o_pl1[1]),
    .out_rd0(o_rd0[1]), .out_rd1(o_rd1[1]), .out_rj0(o_rj0[1]), .out_rj1(o_rj1[1]),
    .out_rk0(o_rk0[1]), .out_rk1(o_rk1[1]), .out_is_alu0(o_alu0[1]), .out_is_alu1(o_alu1[1]),
    .out_is_priv0(o_priv0[1]), .out_is_priv1(o_priv1[1]),
    .out_single(o_single[1]), .occupancy(o_occ[1])
  );

  // Two queued instructions may issue together only if both are plain ALU
  // ops, neither is privileged, and the younger does not read the older's
  // non-zero destination.
  function automatic bit pairable(input ent_t a, input ent_t b);
    return a.alu && b.alu && !a.priv && !b.priv &&
           (a.rd == 0 || (a.rd != b.rj && a.rd != b.rk));
  endfunction

  function automatic ent_t mk(input int rd, input int rj, input int rk, input bit alu, input bit priv);
    ent_t e;
    seq++;
    e.payload = PW'(32'hA500_0000 + seq);
    e.rd = 5'(rd); e.rj = 5'(rj); e.rk = 5'(rk);
    e.alu = alu; e.priv = priv;
    return e;
  endfunction

  function automatic ent_t mk_rand();
    ent_t e;
    e.payload = $urandom;
    e.rd = 5'($urandom_range(0, 3));
    e.rj = 5'($urandom_range(0, 3));
    e.rk = 5'($urandom_range(0, 3));
    e.alu = ($urandom_range(0, 9) < 8);
    e.priv = ($urandom_range(0, 9) == 0);
    return e;
  endfunction

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare one instance against its scoreboard queue, then retire whatever
  // that instance issues at the coming edge.
  task automatic check_lane(input int k);
    ent_t       q[$];
    logic [1:0] ev;
    int         n;
    string      tag;
    if (k == 0) begin q = qa; tag = "dual"; end
    else        begin q = qb; tag = "single"; end
    n = q.size();
    cnt_at[k] = n;
    ev = 2'b00;
    if (n >= 1 && !hold[k]) ev[0] = 1'b1;
    if (ev[0] && n >= 2 && k == 0) ev[1] = pairable(q[0], q[1]);
    check_output({tag, ".in_ready"},  64'(o_in_ready[k]), 64'(n <= DEPTH - 2));
    check_output({tag, ".occupancy"}, 64'(o_occ[k]),      64'(n));
    check_output({tag, ".out_valid"}, 64'(o_valid[k]),    64'(ev));
    check_output({tag, ".out_single"}, 64'(o_single[k]),  64'(ev == 2'b01));
    if (ev[0])
      check_output({tag, ".lane0"}, 64'({o_pl0[k], o_rd0[k], o_rj0[k], o_rk0[k], o_alu0[k], o_priv0[k]}), 64'(q[0]));
    if (ev[1])
      check_output({tag, ".lane1"}, 64'({o_pl1[k], o_rd1[k], o_rj1[k], o_rk1[k], o_alu1[k], o_priv1[k]}), 64'(q[1]));
    else
      check_output({tag, ".nop_slot"}, 64'({o_rd1[k], o_alu1[k]}), 64'({5'd0, 1'b1}));
    if (flush) begin
      hold[k] = 1'b0;
    end else if (out_ready && ev[0]) begin
      hold[k] = q[0].priv;
      void'(q.pop_front());
      if (ev[1]) void'(q.pop_front());
    end else begin
      hold[k] = 1'b0;
    end
    if (k == 0) qa = q; else qb = q;
  endtask

  // Monitor: mid-cycle, after the inputs for this cycle have settled.
  always begin
    @(negedge clk);
    #2;
    if (!rstn) begin
      qa.delete(); qb.delete();
      hold = '{1'b0, 1'b0};
      cnt_at = '{0, 0};
    end else begin
      check_lane(0);
      check_lane(1);
    end
  end

  // Issue side: record what each instance accepts at this edge.
  always @(posedge clk) begin
    if (rstn) begin
      if (flush) begin
        qa.delete(); qb.delete();
      end else if (in_valid[0]) begin
        if (cnt_at[0] <= DEPTH - 2) begin
          qa.push_back(in_e0);
          if (in_valid[1]) qa.push_back(in_e1);
        end
        if (cnt_at[1] <= DEPTH - 2) begin
          qb.push_back(in_e0);
          if (in_valid[1]) qb.push_back(in_e1);
        end
      end
    end
  end

  task automatic apply_stimulus(input logic [1:0] iv, input logic ordy, input logic fl, input ent_t e0, input ent_t e1);
    @(negedge clk);
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    in_e0     = e0;
    in_e1     = e1;
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) apply_stimulus(2'b00, ordy, 1'b0, '0, '0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // Independent ALU pair: dual issue on the dual instance.
    apply_stimulus(2'b11, 1'b1, 1'b0, mk(3, 1, 2, 1, 0), mk(5, 4, 6, 1, 0));
    idle(3, 1'b1);

    // RAW through rd=3 blocks pairing; rd=0 does not.
    apply_stimulus(2'b11, 1'b1, 1'b0, mk(3, 1, 2, 1, 0), mk(7, 3, 0, 1, 0));
    idle(3, 1'b1);
    apply_stimulus(2'b11, 1'b1, 1'b0, mk(0, 1, 2, 1, 0), mk(7, 0, 0, 1, 0));
    idle(3, 1'b1);

    // Priv op followed by ALU op: one bubble after the priv op leaves.
    apply_stimulus(2'b11, 1'b1, 1'b0, mk(1, 0, 0, 0, 1), mk(2, 0, 0, 1, 0));
    idle(4, 1'b1);

    // Fill to DEPTH with downstream stalled, then drain across the wrap.
    for (int i = 0; i < 4; i++)
      apply_stimulus(2'b11, 1'b0, 1'b0, mk(i + 8, 1, 2, 1, 0), mk(i + 16, 4, 5, 1, 0));
    apply_stimulus(2'b11, 1'b0, 1'b0, mk(9, 9, 9, 1, 0), mk(9, 9, 9, 1, 0));
    for (int i = 0; i < 6; i++)
      apply_stimulus(2'b01, 1'b1, 1'b0, mk(i + 1, 0, 0, 1, 0), '0);
    idle(12, 1'b1);

    // Five entries queued, then flush with a pair on the inputs.
    apply_stimulus(2'b11, 1'b0, 1'b0, mk(1, 0, 0, 1, 0), mk(2, 0, 0, 1, 0));
    apply_stimulus(2'b11, 1'b0, 1'b0, mk(3, 0, 0, 1, 0), mk(4, 0, 0, 1, 0));
    apply_stimulus(2'b01, 1'b0, 1'b0, mk(5, 0, 0, 1, 0), '0);
    apply_stimulus(2'b11, 1'b0, 1'b1, mk(6, 0, 0, 1, 0), mk(7, 0, 0, 1, 0));
    idle(3, 1'b1);

    // Six entries queued, then asynchronous reset mid-cycle.
    for (int i = 0; i < 3; i++)
      apply_stimulus(2'b11, 1'b0, 1'b0, mk(i, 1, 1, 1, 0), mk(i, 2, 2, 1, 0));
    idle(1, 1'b0);
    #3;
    rstn = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check_output("async_reset.out_valid", 64'(o_valid[k]), 64'd0);
      check_output("async_reset.occupancy", 64'(o_occ[k]), 64'd0);
      check_output("async_reset.in_ready", 64'(o_in_ready[k]), 64'd1);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 2000; i++) begin
      logic [1:0] iv;
      case ($urandom_range(0, 2))
        0:       iv = 2'b00;
        1:       iv = 2'b01;
        default: iv = 2'b11;
      endcase
      apply_stimulus(iv, ($urandom_range(0, 9) < 7), ($urandom_range(0, 49) == 0), mk_rand(), mk_rand());
    end
    idle(20, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
